proc_multicycle_core: RTL and testbench
=======================================

// Module: proc_multicycle_core
// PURPOSE
//  Parametrised multi-cycle successor of the 8-bit single-cycle processor datapath.
//  Accepts one register-register instruction per valid/ready handshake and runs it through IDLE->READ->EXEC->WB.
//  Writes the result to an internal register file and reports result plus flags with a 1-cycle out_valid pulse.
//  Sits between the instruction sequencer (upstream) and result/debug consumers (downstream).
// PARAMETERS
//  DATA_W  8  datapath and register width in bits (>=4)
//  NREGS   8  number of architectural registers (power of 2, >=2); RA_W = $clog2(NREGS)
// PORTS
//  clk         in   1       single clock, rising edge
//  rst_n       in   1       asynchronous, active-low reset
//  in_valid    in   1       instruction fields valid
//  in_ready    out  1       core can accept; high only in IDLE
//  opcode      in   4       operation, see table
//  rs          in   RA_W    source register A
//  rt          in   RA_W    source register B
//  rd          in   RA_W    destination register
//  out_valid   out  1       1-cycle pulse in WB
//  out_result  out  DATA_W  result of last completed instruction
//  out_zero    out  1       out_result == 0
//  out_carry   out  1       ADD carry-out / SUB borrow / 0 otherwise
//  busy        out  1       state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; all registers, out_result, out_zero, out_carry = 0; out_valid = 0; busy = 0; in_ready = 1 after release.
//  Reset mid-operation: instruction aborted, no regfile write, no out_valid.
//  Accept: in_valid && in_ready at edge T latches opcode/rs/rt/rd.
//   T+1 READ: latch A=R[rs], B=R[rt].
//   T+2 EXEC: compute.
//   T+3 WB: R[rd] written, outputs updated, out_valid=1.
//   T+4 IDLE.
//  Latency 3 cycles accept->out_valid; throughput 1 instr per 4 cycles.
//  Dependent back-to-back instruction reads the updated value; no forwarding needed.
//  R0 reads as 0 always; writes to R0 are discarded, but out_* still report the computed result.
//  Opcodes:
//   0 ADD    1 SUB    2 AND    3 OR    4 XOR
//   5 NOT A  6 MOV A  7 MUL    8 SLTU (result 1 if A<B unsigned, else 0)
//   9-15 NOP: no write, out_valid still pulses, out_result=0, zero=1, carry=0.
//  Arithmetic:
//   - Arithmetic is modulo 2^DATA_W.
//   - ADD carry = bit DATA_W of the (DATA_W+1)-bit sum.
//   - SUB carry = borrow (A<B unsigned).
//   - Logic ops, MOV and SLTU give carry 0.
//  Outputs hold between WB pulses; in_valid is ignored while not IDLE.
// CONFIGURATION
//  PROC_MUL_EN defined: opcode 7 = iterative shift-add multiply.
//   - EXEC lasts DATA_W cycles; result = low DATA_W bits of A*B.
//   - carry = 1 if any high-half product bit is nonzero.
//   - Latency becomes DATA_W+2.
//  PROC_MUL_EN undefined: opcode 7 behaves as NOP; EXEC is always 1 cycle.
// STRUCTURE
//  Package proc_pkg: opcode localparams (OP_ADD..OP_SLTU, OP_MUL), FSM state encoding (S_IDLE, S_READ, S_EXEC, S_WB).
//  Sub-module proc_regfile #(DATA_W, NREGS):
//   - 2 async read ports, 1 sync write port.
//   - Async active-low clear; R0 hardwired to 0.
//  Core holds the FSM, operand latches, combinational ALU, and (under PROC_MUL_EN) the multiply counter/accumulator.
// TESTING
//  1 Reset then ADD R1=R0+R0 -> out_valid at T+3, result 0x00, zero=1, carry=0, in_ready low T+1..T+3.
//  2 Seed via MOV (preload R2=0xF0, R3=0x20 with test hook or ADD chain); ADD R4=R2+R3 -> 0x10, carry=1; SUB R5=R3-R2 -> 0x30, carry=1.
//  3 Dependent pair: XOR R1=R2^R3 then MOV R6=R1 issued at first ready -> R6 result 0xD0; write to R0 then read R0 -> 0.
//  4 in_valid held high with changing fields during READ..WB -> only first instruction executes; opcode 12 -> NOP pulse, no regfile change.
//  5 Assert rst_n low during EXEC -> no out_valid, all registers 0, in_ready=1 after release.
//  6 PROC_MUL_EN: MUL 0x0F*0x11 -> 0xFF, carry=0, out_valid at T+DATA_W+2; 0x10*0x10 -> 0x00, carry=1; without macro -> NOP.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared definitions for the multi-cycle processor core: opcode encodings and FSM states.
// Optional feature macro: PROC_MUL_EN (iterative shift-add multiply on opcode 7).
package proc_pkg;

    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
    localparam logic [OP_W-1:0] OP_AND  = 4'd2;
    localparam logic [OP_W-1:0] OP_OR   = 4'd3;
    localparam logic [OP_W-1:0] OP_XOR  = 4'd4;
    localparam logic [OP_W-1:0] OP_NOTA = 4'd5;
    localparam logic [OP_W-1:0] OP_MOVA = 4'd6;
    localparam logic [OP_W-1:0] OP_MUL  = 4'd7;
    localparam logic [OP_W-1:0] OP_SLTU = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

endpackage

// File: rtl/proc_regfile.sv
// Architectural register file: two asynchronous read ports, one synchronous write port.
// R0 always reads as zero and ignores writes; async active-low clear of all entries.
module proc_regfile #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NREGS  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [$clog2(NREGS)-1:0]   i_raddr_a,
    input  logic [$clog2(NREGS)-1:0]   i_raddr_b,
    output logic [DATA_W-1:0]          o_rdata_a,
    output logic [DATA_W-1:0]          o_rdata_b,
    input  logic                       i_we,
    input  logic [$clog2(NREGS)-1:0]   i_waddr,
    input  logic [DATA_W-1:0]          i_wdata
);

    localparam int unsigned RA_W = $clog2(NREGS);

    logic [DATA_W-1:0] r_mem [NREGS];

    // Storage update: clear on reset, single write port, R0 never written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (i_waddr != RA_W'(0))) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Asynchronous reads with R0 forced to zero
    always_comb begin
        o_rdata_a = (i_raddr_a == RA_W'(0)) ? '0 : r_mem[i_raddr_a];
        o_rdata_b = (i_raddr_b == RA_W'(0)) ? '0 : r_mem[i_raddr_b];
    end

endmodule

// File: rtl/proc_multicycle_core.sv
// Multi-cycle register-register processor core: IDLE -> READ -> EXEC -> WB per instruction.
// Optional macro PROC_MUL_EN: opcode 7 becomes a DATA_W-cycle shift-add multiply;
// without it opcode 7 is a NOP and EXEC is always a single cycle.
module proc_multicycle_core
    import proc_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NREGS  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [3:0]                 opcode,
    input  logic [$clog2(NREGS)-1:0]   rs,
    input  logic [$clog2(NREGS)-1:0]   rt,
    input  logic [$clog2(NREGS)-1:0]   rd,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_result,
    output logic                       out_zero,
    output logic                       out_carry,
    output logic                       busy
);

    localparam int unsigned RA_W = $clog2(NREGS);
`ifdef PROC_MUL_EN
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);
    localparam int unsigned PRD_W = 2 * DATA_W;
`endif

    state_t            r_state;
    logic [OP_W-1:0]   r_op;
    logic [RA_W-1:0]   r_rs;
    logic [RA_W-1:0]   r_rt;
    logic [RA_W-1:0]   r_rd;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_result;
    logic              r_zero;
    logic              r_carry;
    logic              r_out_valid;
    logic              r_busy;
    logic              r_in_ready;
    logic              r_wr_en;

`ifdef PROC_MUL_EN
    logic [PRD_W-1:0]  r_acc;
    logic [PRD_W-1:0]  r_mcd;
    logic [DATA_W-1:0] r_mpl;
    logic [CNT_W-1:0]  r_cnt;
    logic [PRD_W-1:0]  w_acc_next;
`endif

    logic [DATA_W-1:0] w_rdata_a;
    logic [DATA_W-1:0] w_rdata_b;
    logic              w_we;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W:0]   w_diff;
    logic [DATA_W-1:0] w_alu_res;
    logic              w_alu_carry;
    logic              w_alu_wr;

    assign w_we = (r_state == S_WB) && r_wr_en;

    proc_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_raddr_a (r_rs),
        .i_raddr_b (r_rt),
        .o_rdata_a (w_rdata_a),
        .o_rdata_b (w_rdata_b),
        .i_we      (w_we),
        .i_waddr   (r_rd),
        .i_wdata   (r_result)
    );

    // Single-cycle ALU on latched operands; w_alu_wr marks ops that update the regfile
    always_comb begin
        w_sum       = {1'b0, r_a} + {1'b0, r_b};
        w_diff      = {1'b0, r_a} - {1'b0, r_b};
        w_alu_res   = '0;
        w_alu_carry = 1'b0;
        w_alu_wr    = 1'b0;
        case (r_op)
            OP_ADD: begin
                w_alu_res   = w_sum[DATA_W-1:0];
                w_alu_carry = w_sum[DATA_W];
                w_alu_wr    = 1'b1;
            end
            OP_SUB: begin
                w_alu_res   = w_diff[DATA_W-1:0];
                w_alu_carry = w_diff[DATA_W];
                w_alu_wr    = 1'b1;
            end
            OP_AND: begin
                w_alu_res = r_a & r_b;
                w_alu_wr  = 1'b1;
            end
            OP_OR: begin
                w_alu_res = r_a | r_b;
                w_alu_wr  = 1'b1;
            end
            OP_XOR: begin
                w_alu_res = r_a ^ r_b;
                w_alu_wr  = 1'b1;
            end
            OP_NOTA: begin
                w_alu_res = ~r_a;
                w_alu_wr  = 1'b1;
            end
            OP_MOVA: begin
                w_alu_res = r_a;
                w_alu_wr  = 1'b1;
            end
            OP_SLTU: begin
                w_alu_res = DATA_W'(r_a < r_b);
                w_alu_wr  = 1'b1;
            end
            default: begin
                w_alu_res   = '0;
                w_alu_carry = 1'b0;
                w_alu_wr    = 1'b0;
            end
        endcase
    end

`ifdef PROC_MUL_EN
    // One shift-add step: add the shifted multiplicand when the current multiplier bit is set
    always_comb begin
        w_acc_next = r_acc + (r_mpl[0] ? r_mcd : '0);
    end
`endif

    // Instruction sequencer with registered handshake, status and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_op        <= '0;
            r_rs        <= '0;
            r_rt        <= '0;
            r_rd        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_carry     <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_wr_en     <= 1'b0;
`ifdef PROC_MUL_EN
            r_acc       <= '0;
            r_mcd       <= '0;
            r_mpl       <= '0;
            r_cnt       <= '0;
`endif
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_op       <= opcode;
                        r_rs       <= rs;
                        r_rt       <= rt;
                        r_rd       <= rd;
                        r_busy     <= 1'b1;
                        r_in_ready <= 1'b0;
                        r_state    <= S_READ;
                    end
                end
                S_READ: begin
                    r_a     <= w_rdata_a;
                    r_b     <= w_rdata_b;
`ifdef PROC_MUL_EN
                    r_acc   <= '0;
                    r_mcd   <= PRD_W'(w_rdata_a);
                    r_mpl   <= w_rdata_b;
                    r_cnt   <= '0;
`endif
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
`ifdef PROC_MUL_EN
                    if (r_op == OP_MUL) begin
                        r_acc <= w_acc_next;
                        r_mcd <= r_mcd << 1;
                        r_mpl <= r_mpl >> 1;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_W'(DATA_W - 1)) begin
                            r_result    <= w_acc_next[DATA_W-1:0];
                            r_zero      <= (w_acc_next[DATA_W-1:0] == '0);
                            r_carry     <= |w_acc_next[PRD_W-1:DATA_W];
                            r_wr_en     <= 1'b1;
                            r_out_valid <= 1'b1;
                            r_state     <= S_WB;
                        end
                    end else
`endif
                    begin
                        r_result    <= w_alu_res;
                        r_zero      <= (w_alu_res == '0);
                        r_carry     <= w_alu_carry;
                        r_wr_en     <= w_alu_wr;
                        r_out_valid <= 1'b1;
                        r_state     <= S_WB;
                    end
                end
                S_WB: begin
                    r_wr_en    <= 1'b0;
                    r_busy     <= 1'b0;
                    r_in_ready <= 1'b1;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign busy       = r_busy;
    assign out_valid  = r_out_valid;
    assign out_result = r_result;
    assign out_zero   = r_zero;
    assign out_carry  = r_carry;

endmodule

// File: tb/tb_proc_multicycle_core.sv
// Directed bench for proc_multicycle_core (default parameters DATA_W=8, NREGS=8).
// Build with PROC_MUL_EN defined to exercise the multiply; otherwise opcode 7 is a NOP.
module tb_proc_multicycle_core;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] opcode;
    logic [2:0] rs;
    logic [2:0] rt;
    logic [2:0] rd;
    logic       out_valid;
    logic [7:0] out_result;
    logic       out_zero;
    logic       out_carry;
    logic       busy;

    int n_chk  = 0;
    int n_pass = 0;

`ifdef PROC_MUL_EN
    localparam int MUL_LAT = 10;
`else
    localparam int MUL_LAT = 3;
`endif

    proc_multicycle_core #(.DATA_W(8), .NREGS(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .opcode     (opcode),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .out_valid  (out_valid),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_carry  (out_carry),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Wait (bounded) at negedges for the core to be ready
    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
    endtask

    // Issue one instruction and check latency, handshake and results
    task automatic run(input string tag, input logic [3:0] op, input logic [2:0] a,
                       input logic [2:0] b, input logic [2:0] d, input logic [7:0] er,
                       input logic ec, input int lat);
        int   cyc;
        logic seen;
        logic hs_ok;
        wait_ready(tag);
        opcode   = op;
        rs       = a;
        rt       = b;
        rd       = d;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        cyc   = 0;
        seen  = 1'b0;
        hs_ok = 1'b1;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (in_ready || !busy) hs_ok = 1'b0;
            if (out_valid) seen = 1'b1;
        end
        check({tag, "_lat"},    32'(cyc),        32'(lat));
        check({tag, "_res"},    32'(out_result), 32'(er));
        check({tag, "_zero"},   32'(out_zero),   32'(er == 8'h00));
        check({tag, "_carry"},  32'(out_carry),  32'(ec));
        check({tag, "_hs"},     32'(hs_ok),      32'd1);
        @(negedge clk);
        check({tag, "_pulse"},  32'(out_valid),  32'd0);
        check({tag, "_hold"},   32'(out_result), 32'(er));
    endtask

    initial begin
        int   cyc;
        int   pulses;
        logic seen;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        opcode   = '0;
        rs       = '0;
        rt       = '0;
        rd       = '0;
        repeat (3) @(negedge clk);
        check("rst_valid",  32'(out_valid),  32'd0);
        check("rst_busy",   32'(busy),       32'd0);
        check("rst_result", 32'(out_result), 32'd0);
        check("rst_zero",   32'(out_zero),   32'd0);
        check("rst_carry",  32'(out_carry),  32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_ready",  32'(in_ready),   32'd1);

        // Basic op after reset and constant-building chain
        run("add_r0r0",  4'd0, 3'd0, 3'd0, 3'd1, 8'h00, 1'b0, 3);
        run("not_r0",    4'd5, 3'd0, 3'd0, 3'd1, 8'hFF, 1'b0, 3);
        run("sltu_t",    4'd8, 3'd0, 3'd1, 3'd7, 8'h01, 1'b0, 3);
        run("dbl2",      4'd0, 3'd7, 3'd7, 3'd3, 8'h02, 1'b0, 3);
        run("dbl4",      4'd0, 3'd3, 3'd3, 3'd3, 8'h04, 1'b0, 3);
        run("dbl8",      4'd0, 3'd3, 3'd3, 3'd3, 8'h08, 1'b0, 3);
        run("dbl16",     4'd0, 3'd3, 3'd3, 3'd3, 8'h10, 1'b0, 3);
        run("sub_0f",    4'd1, 3'd3, 3'd7, 3'd6, 8'h0F, 1'b0, 3);
        run("add_11",    4'd0, 3'd3, 3'd7, 3'd4, 8'h11, 1'b0, 3);

        // Multiply (or NOP when the feature is absent)
`ifdef PROC_MUL_EN
        run("mul_0f11",  4'd7, 3'd6, 3'd4, 3'd5, 8'hFF, 1'b0, MUL_LAT);
        run("mul_1010",  4'd7, 3'd3, 3'd3, 3'd5, 8'h00, 1'b1, MUL_LAT);
        run("mov_mulr",  4'd6, 3'd5, 3'd0, 3'd1, 8'h00, 1'b0, 3);
`else
        run("mul_nop1",  4'd7, 3'd6, 3'd4, 3'd5, 8'h00, 1'b0, MUL_LAT);
        run("mul_nop2",  4'd7, 3'd3, 3'd3, 3'd5, 8'h00, 1'b0, MUL_LAT);
        run("mov_mulr",  4'd6, 3'd5, 3'd0, 3'd1, 8'h00, 1'b0, 3);
`endif

        run("not_f0",    4'd5, 3'd6, 3'd0, 3'd2, 8'hF0, 1'b0, 3);
        run("dbl32",     4'd0, 3'd3, 3'd3, 3'd3, 8'h20, 1'b0, 3);

        // Arithmetic with carry / borrow, logic ops
        run("add_wrap",  4'd0, 3'd2, 3'd3, 3'd4, 8'h10, 1'b1, 3);
        run("sub_borr",  4'd1, 3'd3, 3'd2, 3'd5, 8'h30, 1'b1, 3);
        run("and",       4'd2, 3'd2, 3'd3, 3'd6, 8'h20, 1'b0, 3);
        run("or",        4'd3, 3'd2, 3'd3, 3'd6, 8'hF0, 1'b0, 3);
        run("sltu_f",    4'd8, 3'd2, 3'd3, 3'd7, 8'h00, 1'b0, 3);

        // Dependent pair and R0 discard
        run("xor_dep",   4'd4, 3'd2, 3'd3, 3'd1, 8'hD0, 1'b0, 3);
        run("mov_dep",   4'd6, 3'd1, 3'd0, 3'd6, 8'hD0, 1'b0, 3);
        run("wr_r0",     4'd0, 3'd2, 3'd3, 3'd0, 8'h10, 1'b1, 3);
        run("rd_r0",     4'd6, 3'd0, 3'd0, 3'd5, 8'h00, 1'b0, 3);

        // in_valid held high with changing fields while busy
        wait_ready("hold");
        opcode   = 4'd0;
        rs       = 3'd2;
        rt       = 3'd2;
        rd       = 3'd4;
        in_valid = 1'b1;
        @(posedge clk);
        cyc    = 0;
        seen   = 1'b0;
        pulses = 0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            opcode = 4'd4;
            rs     = 3'd2;
            rt     = 3'd3;
            rd     = 3'd5;
            if (out_valid) begin
                seen     = 1'b1;
                pulses++;
                in_valid = 1'b0;
            end
        end
        check("hold_lat",   32'(cyc),        32'd3);
        check("hold_res",   32'(out_result), 32'hE0);
        check("hold_carry", 32'(out_carry),  32'd1);
        repeat (4) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        check("hold_pulses", 32'(pulses),    32'd1);
        check("hold_idle",   32'(busy),      32'd0);
        run("hold_r5",   4'd6, 3'd5, 3'd0, 3'd7, 8'h00, 1'b0, 3);
        run("hold_r4",   4'd6, 3'd4, 3'd0, 3'd7, 8'hE0, 1'b0, 3);

        // NOP opcode leaves the register file alone
        run("nop12",     4'd12, 3'd2, 3'd3, 3'd2, 8'h00, 1'b0, 3);
        run("nop_chk",   4'd6,  3'd2, 3'd0, 3'd7, 8'hF0, 1'b0, 3);

        // Reset asserted during EXEC aborts the instruction
        wait_ready("rstx");
        opcode   = 4'd0;
        rs       = 3'd2;
        rt       = 3'd3;
        rd       = 3'd1;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rstx_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstx_valid",  32'(out_valid),  32'd0);
        check("rstx_bsy0",   32'(busy),       32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        check("rstx_pulses", 32'(pulses),     32'd0);
        check("rstx_ready",  32'(in_ready),   32'd1);
        check("rstx_result", 32'(out_result), 32'd0);
        run("rstx_r2",   4'd6, 3'd2, 3'd0, 3'd1, 8'h00, 1'b0, 3);
        run("rstx_r4",   4'd3, 3'd4, 3'd3, 3'd1, 8'h00, 1'b0, 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
